// File: rtl/composite_frame_seq_if.sv
// Row-fetch handshake between the vertical sequencer (master) and the
// framebuffer fetch unit (slave).
interface composite_frame_seq_if;
    logic       row_req;
    logic [8:0] row_addr;
    logic       row_ack;

    modport master (
        output row_req,
        output row_addr,
        input  row_ack
    );

    modport slave (
        input  row_req,
        input  row_addr,
        output row_ack
    );
endinterface

// File: rtl/composite_frame_seq.sv
// Vertical field/frame sequencer: counts lines, classifies them and requests
// framebuffer rows one line ahead. Define COMPOSITE_INTERLACE_EN for interlaced fields.
module composite_frame_seq #(
    parameter int LINES_PER_FIELD = 262,
    parameter int EQ_LINES        = 3,
    parameter int VSYNC_LINES     = 3,
    parameter int BLANK_END       = 21
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        line_end,
    input  logic                        underrun_clr,
    composite_frame_seq_if.master       row,
    output logic [9:0]                  line_num,
    output logic [1:0]                  line_type,
    output logic                        active_line,
    output logic                        field,
    output logic                        frame_start,
    output logic                        underrun
);

    typedef enum logic [1:0] {
        LT_BLANK      = 2'd0,
        LT_EQUALIZING = 2'd1,
        LT_VSYNC      = 2'd2,
        LT_ACTIVE     = 2'd3
    } line_type_t;

    localparam logic [9:0] EQ1_END   = 10'(EQ_LINES);
    localparam logic [9:0] VSYNC_END = 10'(EQ_LINES + VSYNC_LINES);
    localparam logic [9:0] EQ2_END   = 10'(2 * EQ_LINES + VSYNC_LINES);
    localparam logic [9:0] ACT_START = 10'(BLANK_END);
    localparam logic [9:0] REQ_START = 10'(BLANK_END - 1);
    localparam logic [9:0] LAST_BASE = 10'(LINES_PER_FIELD - 1);

    function automatic line_type_t classify(input logic [9:0] n);
        if (n < EQ1_END)        return LT_EQUALIZING;
        else if (n < VSYNC_END) return LT_VSYNC;
        else if (n < EQ2_END)   return LT_EQUALIZING;
        else if (n < ACT_START) return LT_BLANK;
        else                    return LT_ACTIVE;
    endfunction

    line_type_t line_type_q;
    line_type_t next_type;
    logic       row_req_q;
    logic [8:0] row_addr_q;
    logic       accept;
    logic       at_last;
    logic       due;
    logic       stale;
    logic [9:0] last_line;
    logic [9:0] next_num;
    logic [8:0] next_addr;

    // Request for line L+1 goes out on entering line L; the stale check looks at
    // the request outstanding before this edge, so a coincident ack forgives it.
    always_comb begin
        accept    = enable && line_end;
`ifdef COMPOSITE_INTERLACE_EN
        last_line = LAST_BASE + {9'd0, field};
        next_addr = {8'(next_num - REQ_START), field};
`else
        last_line = LAST_BASE;
        next_addr = 9'(next_num - REQ_START);
`endif
        at_last   = (line_num == last_line);
        next_num  = at_last ? 10'd0 : line_num + 10'd1;
        next_type = classify(next_num);
        due       = (next_num >= REQ_START) && (next_num < last_line);
        stale     = row_req_q && !row.row_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_num    <= 10'd0;
            line_type_q <= LT_EQUALIZING;
            active_line <= 1'b0;
            field       <= 1'b0;
            frame_start <= 1'b0;
            row_req_q   <= 1'b0;
            row_addr_q  <= 9'd0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                line_num    <= next_num;
                line_type_q <= next_type;
                active_line <= (next_type == LT_ACTIVE);
                frame_start <= at_last;
`ifdef COMPOSITE_INTERLACE_EN
                field       <= field ^ at_last;
`endif
                row_req_q   <= due;
                if (due) begin
                    row_addr_q <= next_addr;
                end
                if (stale) begin
                    underrun <= 1'b1;
                end else if (underrun_clr) begin
                    underrun <= 1'b0;
                end
            end else begin
                if (row_req_q && row.row_ack) begin
                    row_req_q <= 1'b0;
                end
                if (underrun_clr) begin
                    underrun <= 1'b0;
                end
            end
        end
    end

    assign line_type    = line_type_q;
    assign row.row_req  = row_req_q;
    assign row.row_addr = row_addr_q;

endmodule

// File: tb/tb_composite_frame_seq.sv
// Scoreboard bench for composite_frame_seq: a line-level reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_composite_frame_seq;

    localparam int LINES_PER_FIELD = 262;
    localparam int BLANK_END       = 21;
`ifdef COMPOSITE_INTERLACE_EN
    localparam int ILACE = 1;
`else
    localparam int ILACE = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       line_end = 1'b0;
    logic       underrun_clr = 1'b0;
    logic [9:0] line_num;
    logic [1:0] line_type;
    logic       active_line;
    logic       field;
    logic       frame_start;
    logic       underrun;

    composite_frame_seq_if rif ();

    composite_frame_seq dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .line_end     (line_end),
        .underrun_clr (underrun_clr),
        .row          (rif),
        .line_num     (line_num),
        .line_type    (line_type),
        .active_line  (active_line),
        .field        (field),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int line;
        int ltype;
        int active;
        int fld;
        int fs;
        int req;
        int addr;
        int under;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int m_line = 0;
    int m_field = 0;
    int m_req = 0;
    int m_addr = 0;
    int m_under = 0;
    int m_fs = 0;

    function automatic int line_class(input int l);
        if (l < 3)              return 1;
        else if (l < 6)         return 2;
        else if (l < 9)         return 1;
        else if (l < BLANK_END) return 0;
        else                    return 3;
    endfunction

    // Reference model: state after the coming edge given this cycle's inputs.
    task automatic modelStep(input bit rst, input bit en, input bit le, input bit ack, input bit clr);
        int last;
        bit stale;
        if (rst) begin
            m_line = 0; m_field = 0; m_req = 0; m_addr = 0; m_under = 0; m_fs = 0;
        end else begin
            m_fs = 0;
            if (en && le) begin
                stale = (m_req != 0) && !ack;
                last  = LINES_PER_FIELD - 1 + ILACE * m_field;
                if (m_line == last) begin
                    m_line = 0;
                    m_fs = 1;
                    if (ILACE != 0) m_field = 1 - m_field;
                end else begin
                    m_line = m_line + 1;
                end
                if (m_line >= BLANK_END - 1 && m_line < last) begin
                    m_req  = 1;
                    m_addr = ((m_line + 1 - BLANK_END) * (ILACE + 1) + ILACE * m_field) % 512;
                end else begin
                    m_req = 0;
                end
                if (stale) m_under = 1;
                else if (clr) m_under = 0;
            end else begin
                if (m_req != 0 && ack) m_req = 0;
                if (clr) m_under = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit le, input bit ack, input bit clr);
        exp_t e;
        @(negedge clk);
        #1;
        reset        = rst;
        enable       = en;
        line_end     = le;
        rif.row_ack  = ack;
        underrun_clr = clr;
        modelStep(rst, en, le, ack, clr);
        e.line = m_line; e.ltype = line_class(m_line); e.active = (line_class(m_line) == 3) ? 1 : 0;
        e.fld = m_field; e.fs = m_fs; e.req = m_req; e.addr = m_addr; e.under = m_under;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        bit ok;
        vectors++;
        ok = (int'(line_num) == e.line) && (int'(line_type) == e.ltype) && (int'(active_line) == e.active) &&
             (int'(field) == e.fld) && (int'(frame_start) == e.fs) && (int'(rif.row_req) == e.req) &&
             (int'(rif.row_addr) == e.addr) && (int'(underrun) == e.under);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t actual line=%0d type=%0d act=%0d fld=%0d fs=%0d req=%0d addr=%0d und=%0d required line=%0d type=%0d act=%0d fld=%0d fs=%0d req=%0d addr=%0d und=%0d",
                     name, $time, line_num, line_type, active_line, field, frame_start, rif.row_req, rif.row_addr, underrun,
                     e.line, e.ltype, e.active, e.fld, e.fs, e.req, e.addr, e.under);
        end
    endtask

    // Monitor: pops one prediction for every edge the driver has issued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput("outputs", exp_q.pop_front());
        end
    end

    task automatic randomLines(input int count);
        int gap;
        bit en;
        for (int n = 0; n < count; n++) begin
            gap = $urandom_range(5, 12);
            for (int c = 0; c < gap; c++) begin
                en = ($urandom_range(0, 9) != 0);
                applyStimulus(0, en, 0, (m_req != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0),
                              $urandom_range(0, 39) == 0);
            end
            en = ($urandom_range(0, 9) != 0);
            applyStimulus(0, en, 1, (m_req != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        rif.row_ack = 1'b0;
        $display("[TB] composite_frame_seq scoreboard run, interlace=%0d", ILACE);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0);

        // First nine lines at realistic line spacing.
        for (int n = 0; n < 9; n++) begin
            for (int c = 0; c < 3175; c++) applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 1, 1, 0, 0);
        end

        // Up to line 20, ack the row 5 cycles later, then starve the line-21 request.
        while (m_line < 20) begin
            for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 1, 1, 0, 0);
        end
        for (int c = 0; c < 4; c++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        for (int c = 0; c < 4; c++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        for (int c = 0; c < 6; c++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);

        // Coincident ack and line_end, then clear racing a new underrun.
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 1);

        randomLines(650);

        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        randomLines(40);

        for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/composite_frame_seq.md
Name: composite_frame_seq

Overview:
- Vertical (field/frame) sequencer for the composite video synthesizer.
- Counts lines using the end-of-line strobe from the horizontal line timer, and classifies each line as equalizing, vsync, blanking or active. This classification selects which horizontal waveform the line generator produces.
- Requests pixel rows from the framebuffer fetch unit one line ahead of display, through a req/ack handshake.
- Flags late fetches.

Parameters:
- LINES_PER_FIELD, 262, lines per field (progressive field length).
- EQ_LINES, 3, length of each equalizing group in lines.
- VSYNC_LINES, 3, vsync lines.
- BLANK_END, 21, index of first active line; ACTIVE_LINES = LINES_PER_FIELD - BLANK_END.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  sequencer run; when low, line_end is ignored and all state holds
- line_end  in  1  one-cycle pulse from horizontal timer at line wrap
- row_ack  in  1  fetch unit accepted the current row request
- underrun_clr  in  1  clears the underrun flag
- line_num  out  10  current line index, 0-based
- line_type  out  2  0=BLANK, 1=EQUALIZING, 2=VSYNC, 3=ACTIVE
- active_line  out  1  high when line_type==ACTIVE
- field  out  1  current field (0/1)
- frame_start  out  1  one-cycle pulse when line_num wraps to 0
- row_req  out  1  row fetch request
- row_addr  out  9  row index for the request; stable while row_req is high
- underrun  out  1  sticky late-fetch flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - line_num=0, line_type=EQUALIZING, active_line=0, field=0.
  - frame_start=0, row_req=0, row_addr=0, underrun=0.
- Line advance: an accepted line_end (enable=1) advances line_num on that clock edge. line_type, active_line and row_req update on the same edge, so there is no added latency.
- Wrap:
  - When line_num==last_line, line_num goes to 0 and frame_start pulses high for exactly one cycle.
  - last_line = LINES_PER_FIELD-1, except as noted under the optional feature.
- Line classification by line_num:
  - 0..EQ_LINES-1: EQUALIZING.
  - next VSYNC_LINES: VSYNC.
  - next EQ_LINES: EQUALIZING.
  - up to BLANK_END-1: BLANK.
  - BLANK_END..last_line: ACTIVE.
- Row request timing:
  - On entering line L, where L+1 is an active line (BLANK_END-1 <= L < last_line), set row_req=1 and row_addr=L+1-BLANK_END.
  - No request is issued on last_line, because line 0 is never active.
- Handshake:
  - row_req && row_ack at an edge clears row_req the next cycle.
  - row_ack while row_req is low is ignored.
  - row_addr holds while row_req is high.
- Underrun: an accepted line_end while row_req is high and row_ack is low sets underrun. The stale request is then either replaced by the new line's request (row_req stays high, row_addr updates) or dropped if no new request is due.
- Simultaneous ack and line_end: the ack completes the old request, the new request (if due) is asserted, and underrun is not set.
- underrun_clr: clears underrun. If it coincides with a new underrun event, set wins.
- enable low:
  - line_end is ignored; counters and outputs hold.
  - A pending row_req stays asserted and can still be acked.
  - frame_start stays 0.
- Reset mid-frame: returns all outputs to reset values on the next edge. Any outstanding request is abandoned without an ack.

Optional Feature:
- Macro: COMPOSITE_INTERLACE_EN.
- Defined:
  - field toggles on every wrap.
  - Field 1 has LINES_PER_FIELD+1 lines, so last_line=LINES_PER_FIELD for field 1.
  - row_addr = 2*(L+1-BLANK_END)+field, and is 10 bits wide internally, truncated to 9 bits.
- Undefined: field is constant 0, every field has LINES_PER_FIELD lines, and row_addr is as in Behaviour.

Test Plan:
- Reset asserted, then released with enable=1 and no line_end -> all outputs at their reset values; line_type=1 and line_num=0 held indefinitely.
- 9 line_end pulses, spaced 3176 cycles apart -> line_type sequence 1,1,1,2,2,2,1,1,1 over lines 0..8, then 0 at line 9.
- Advance to line 20 -> row_req=1, row_addr=0 on the same edge; row_ack 5 cycles later -> row_req=0 on the following cycle; line 21 gives line_type=3, active_line=1.
- At line 21, withhold row_ack through the next line_end -> underrun=1, row_req stays 1, row_addr=2; underrun_clr pulse -> underrun=0.
- 262 line_ends from reset -> line_num 261 issues no request, the next line_end gives line_num=0 and exactly one frame_start pulse; field stays 0 (no macro).
- With COMPOSITE_INTERLACE_EN: field goes 0->1 at the first wrap; field 1 wraps after 263 lines; the line-20 request in field 1 gives row_addr=1.
